// File: rtl/brus16_pkg.sv
// brus16_pkg
// Shared definitions for the BRUS16 operand stack: default data width and
// depth, plus the stack operation encoding driven by the decode stage.
// The optional overflow/underflow guard is selected with DSTACK_GUARD_EN
// in the modules that import this package.
package brus16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 32;

    // Stack operation encoding; codes 6 and 7 behave as NOP.
    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        OP_PUSH    = 3'd1,
        OP_POP     = 3'd2,
        OP_BINOP   = 3'd3,
        OP_REPLACE = 3'd4,
        OP_POP2    = 3'd5
    } stack_op_e;

endpackage

// File: rtl/stack_mem.sv
// stack_mem
// Backing register array for the operand stack: holds every entry below
// TOS and NOS (DEPTH-2 words). After reset it walks a clear pointer over
// all entries, one per cycle, and reports busy until the walk finishes.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   we/waddr/wdata single write port (ignored while clearing or out of range)
//   raddr1/rdata1  asynchronous read port (used for sp-1)
//   raddr2/rdata2  asynchronous read port (used for sp-2)
//   busy           clear walk in progress
module stack_mem
    import brus16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr1,
    output logic [WIDTH-1:0]           rdata1,
    input  logic [$clog2(DEPTH)-1:0]   raddr2,
    output logic [WIDTH-1:0]           rdata2,
    output logic                       busy
);

    localparam int AW   = $clog2(DEPTH);
    localparam int MEMN = DEPTH - 2;

    logic [WIDTH-1:0] mem_q [MEMN];
    logic [WIDTH-1:0] mem_d [MEMN];
    logic [AW-1:0]    clr_ptr_q, clr_ptr_d;
    logic             busy_q, busy_d;

    // The clear walk owns the array while busy; the stack port is locked
    // out upstream during that time, so the two never compete.
    always_comb begin
        mem_d     = mem_q;
        clr_ptr_d = clr_ptr_q;
        busy_d    = busy_q;
        if (busy_q) begin
            mem_d[clr_ptr_q] = '0;
            if (clr_ptr_q == AW'(MEMN - 1)) begin
                busy_d = 1'b0;
            end else begin
                clr_ptr_d = clr_ptr_q + AW'(1);
            end
        end else if (we && (waddr < AW'(MEMN))) begin
            mem_d[waddr] = wdata;
        end
    end

    // Array contents are not reset directly; the walk clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q    <= 1'b1;
            clr_ptr_q <= '0;
        end else begin
            busy_q    <= busy_d;
            clr_ptr_q <= clr_ptr_d;
        end
        mem_q <= mem_d;
    end

    // Addresses outside the array (sp-1/sp-2 wrapping below zero) read 0,
    // which is how refills of missing entries come back empty.
    assign rdata1 = (raddr1 < AW'(MEMN)) ? mem_q[raddr1] : '0;
    assign rdata2 = (raddr2 < AW'(MEMN)) ? mem_q[raddr2] : '0;
    assign busy   = busy_q;

endmodule

// File: rtl/data_stack.sv
// data_stack
// Operand stack in front of the ALU. TOS (b) and NOS (a) live in registers;
// deeper entries spill into stack_mem. One op per cycle when op_valid and
// op_ready; BINOP pops two operands and pushes the ALU result.
// Ports:
//   clk, reset  clock and synchronous active-high reset
//   op_valid    op present this cycle
//   op_ready    low only while the post-reset clear walk runs
//   op          NOP/PUSH/POP/BINOP/REPLACE/POP2 (see brus16_pkg)
//   din         data for PUSH and REPLACE
//   alu_out     ALU result consumed by BINOP
//   a, b        NOS and TOS
//   depth       current entry count
//   err         sticky overflow/underflow flag
//   drain_busy  clear walk in progress
// Configuration: define DSTACK_GUARD_EN to drop overflowing/underflowing ops
// and raise err; without it no checks are made, err stays 0 and the depth
// wraps modulo DEPTH.
module data_stack
    import brus16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     op_valid,
    output logic                     op_ready,
    input  logic [2:0]               op,
    input  logic [WIDTH-1:0]         din,
    input  logic [WIDTH-1:0]         alu_out,
    output logic [WIDTH-1:0]         a,
    output logic [WIDTH-1:0]         b,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     err,
    output logic                     drain_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int DW = AW + 1;

    logic [WIDTH-1:0] tos_q, tos_d;
    logic [WIDTH-1:0] nos_q, nos_d;
    logic [DW-1:0]    depth_q, depth_d;
    logic             err_q, err_d;

    logic [DW-1:0]    next_depth;
    logic [AW-1:0]    sp_idx;
    logic [AW-1:0]    raddr1, raddr2;
    logic [WIDTH-1:0] rdata1, rdata2;
    logic             mem_we;
    logic             busy;
    logic             op_fire;
    logic             apply;

    // sp is the array occupancy: everything below TOS and NOS.
    assign sp_idx = (depth_q > DW'(2)) ? AW'(depth_q - DW'(2)) : '0;
    assign raddr1 = sp_idx - AW'(1);
    assign raddr2 = sp_idx - AW'(2);

    assign op_ready = !busy;
    assign op_fire  = op_valid && op_ready;

`ifdef DSTACK_GUARD_EN
    logic bad;

    // Flags ops whose depth requirement is not met; such ops are dropped.
    always_comb begin
        bad = 1'b0;
        case (op)
            OP_PUSH:             bad = (depth_q == DW'(DEPTH));
            OP_POP, OP_REPLACE:  bad = (depth_q == '0);
            OP_BINOP, OP_POP2:   bad = (depth_q < DW'(2));
            default:             bad = 1'b0;
        endcase
    end

    assign apply = op_fire && !bad;
    assign err_d = err_q | (op_fire && bad);
`else
    assign apply = op_fire;
    assign err_d = 1'b0;
`endif

    // Next TOS/NOS/depth and the spill write. The old NOS only spills when
    // it holds a real entry (depth >= 2).
    always_comb begin
        tos_d      = tos_q;
        nos_d      = nos_q;
        next_depth = depth_q;
        mem_we     = 1'b0;
        if (apply) begin
            case (op)
                OP_PUSH: begin
                    nos_d      = tos_q;
                    tos_d      = din;
                    next_depth = depth_q + DW'(1);
                    mem_we     = (depth_q >= DW'(2));
                end
                OP_POP: begin
                    tos_d      = nos_q;
                    nos_d      = rdata1;
                    next_depth = depth_q - DW'(1);
                end
                OP_BINOP: begin
                    tos_d      = alu_out;
                    nos_d      = rdata1;
                    next_depth = depth_q - DW'(1);
                end
                OP_REPLACE: begin
                    tos_d      = din;
                end
                OP_POP2: begin
                    tos_d      = rdata1;
                    nos_d      = rdata2;
                    next_depth = depth_q - DW'(2);
                end
                default: begin
                    tos_d = tos_q;
                end
            endcase
        end
        // A count past DEPTH (overflow above or wrap below zero) folds back
        // modulo DEPTH; only reachable when the guard is compiled out.
        if (next_depth > DW'(DEPTH)) begin
            depth_d = {1'b0, next_depth[AW-1:0]};
        end else begin
            depth_d = next_depth;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tos_q   <= '0;
            nos_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            tos_q   <= tos_d;
            nos_q   <= nos_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .we     (mem_we),
        .waddr  (sp_idx),
        .wdata  (nos_q),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .raddr2 (raddr2),
        .rdata2 (rdata2),
        .busy   (busy)
    );

    assign a          = nos_q;
    assign b          = tos_q;
    assign depth      = depth_q;
    assign err        = err_q;
    assign drain_busy = busy;

endmodule

// File: tb/tb_data_stack.sv
// tb_data_stack
// Directed bench for data_stack: reset/clear walk, push/pop/binop, spill
// and refill through the array, replace, pop2, ignored ops, overflow,
// underflow and reset in the middle of traffic. Expected values for the
// overflow/underflow steps follow DSTACK_GUARD_EN.
module tb_data_stack;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op;
    logic [15:0] din;
    logic [15:0] alu_out;
    logic [15:0] a;
    logic [15:0] b;
    logic [5:0]  depth;
    logic        err;
    logic        drain_busy;

    int checks = 0;
    int errors = 0;
    int drainCycles;

    data_stack dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op         (op),
        .din        (din),
        .alu_out    (alu_out),
        .a          (a),
        .b          (b),
        .depth      (depth),
        .err        (err),
        .drain_busy (drain_busy)
    );

    // 10 ns clock; stimulus changes and sampling happen on the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One op across one rising edge; returns on the following falling edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [15:0] d,
                                 input logic [15:0] alu);
        op_valid = 1'b1;
        op       = o;
        din      = d;
        alu_out  = alu;
        @(posedge clk);
        @(negedge clk);
        op_valid = 1'b0;
        op       = 3'd0;
    endtask

    // Counts falling edges with drain_busy high, bounded; any pending
    // op_valid is dropped as soon as the walk ends.
    task automatic waitDrain(output int n);
        n = 0;
        while (drain_busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        op_valid = 1'b0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        waitDrain(drainCycles);
        checkOutput("drain_len", drainCycles, 30);
        checkOutput("ready_after_drain", op_ready, 1);
    endtask

    initial begin
        reset    = 1'b1;
        op_valid = 1'b0;
        op       = 3'd0;
        din      = '0;
        alu_out  = '0;

        // Power-up reset and clear walk
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("busy_after_reset", drain_busy, 1);
        checkOutput("ready_low_busy", op_ready, 0);
        waitDrain(drainCycles);
        checkOutput("drain_len", drainCycles, 30);
        checkOutput("ready_after_drain", op_ready, 1);
        checkOutput("reset_depth", depth, 0);
        checkOutput("reset_a", a, 0);
        checkOutput("reset_b", b, 0);
        checkOutput("reset_err", err, 0);

        // PUSH 5, PUSH 7, BINOP 12
        applyStimulus(3'd1, 16'd5, 16'd0);
        applyStimulus(3'd1, 16'd7, 16'd0);
        checkOutput("push2_a", a, 5);
        checkOutput("push2_b", b, 7);
        checkOutput("push2_depth", depth, 2);
        applyStimulus(3'd3, 16'd0, 16'd12);
        checkOutput("binop_b", b, 12);
        checkOutput("binop_a", a, 0);
        checkOutput("binop_depth", depth, 1);
        applyStimulus(3'd2, 16'd0, 16'd0);
        checkOutput("pop_empty_depth", depth, 0);
        checkOutput("pop_empty_b", b, 0);

        // Spill and refill
        for (int i = 1; i <= 6; i++) applyStimulus(3'd1, 16'(i), 16'd0);
        checkOutput("spill_depth", depth, 6);
        checkOutput("spill_a", a, 5);
        checkOutput("spill_b", b, 6);
        applyStimulus(3'd2, 16'd0, 16'd0);
        checkOutput("pop1_b", b, 5);
        checkOutput("pop1_a", a, 4);
        for (int i = 0; i < 3; i++) applyStimulus(3'd2, 16'd0, 16'd0);
        checkOutput("refill_b", b, 2);
        checkOutput("refill_a", a, 1);
        checkOutput("refill_depth", depth, 2);

        // POP2 from depth 4, REPLACE, POP2 down to empty
        applyStimulus(3'd1, 16'd3, 16'd0);
        applyStimulus(3'd1, 16'd4, 16'd0);
        applyStimulus(3'd5, 16'd0, 16'd0);
        checkOutput("pop2_b", b, 2);
        checkOutput("pop2_a", a, 1);
        checkOutput("pop2_depth", depth, 2);
        applyStimulus(3'd4, 16'h0055, 16'd0);
        checkOutput("replace_b", b, 16'h0055);
        checkOutput("replace_a", a, 1);
        checkOutput("replace_depth", depth, 2);
        applyStimulus(3'd5, 16'd0, 16'd0);
        checkOutput("pop2_empty_depth", depth, 0);
        checkOutput("pop2_empty_a", a, 0);
        checkOutput("pop2_empty_b", b, 0);

        // Ignored ops: op code 7 and op_valid low
        applyStimulus(3'd1, 16'd9, 16'd0);
        applyStimulus(3'd7, 16'd3, 16'd3);
        checkOutput("op7_depth", depth, 1);
        checkOutput("op7_b", b, 9);
        op = 3'd1;
        din = 16'd44;
        @(posedge clk);
        @(negedge clk);
        op = 3'd0;
        checkOutput("novalid_depth", depth, 1);
        checkOutput("novalid_b", b, 9);
        applyStimulus(3'd2, 16'd0, 16'd0);
        checkOutput("nop_pop_depth", depth, 0);

        // Overflow
        for (int i = 1; i <= 32; i++) applyStimulus(3'd1, 16'(i), 16'd0);
        checkOutput("full_depth", depth, 32);
        checkOutput("full_b", b, 32);
        checkOutput("full_a", a, 31);
        applyStimulus(3'd1, 16'hBEEF, 16'd0);
`ifdef DSTACK_GUARD_EN
        checkOutput("ovf_depth", depth, 32);
        checkOutput("ovf_b", b, 32);
        checkOutput("ovf_err", err, 1);
`else
        checkOutput("ovf_depth", depth, 1);
        checkOutput("ovf_b", b, 16'hBEEF);
        checkOutput("ovf_a", a, 32);
        checkOutput("ovf_err", err, 0);
`endif

        // Underflow from empty
        doReset();
        checkOutput("reset2_err", err, 0);
        applyStimulus(3'd3, 16'd0, 16'h1234);
`ifdef DSTACK_GUARD_EN
        checkOutput("udf_depth", depth, 0);
        checkOutput("udf_b", b, 0);
        checkOutput("udf_err", err, 1);
`else
        checkOutput("udf_depth", depth, 31);
        checkOutput("udf_b", b, 16'h1234);
        checkOutput("udf_err", err, 0);
`endif

        // Reset mid-stream with a PUSH presented in the same cycle
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(3'd1, 16'(i * 16), 16'd0);
        checkOutput("pre_reset_depth", depth, 4);
        reset    = 1'b1;
        op_valid = 1'b1;
        op       = 3'd1;
        din      = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checkOutput("midreset_depth", depth, 0);
        checkOutput("midreset_a", a, 0);
        checkOutput("midreset_b", b, 0);
        checkOutput("midreset_busy", drain_busy, 1);
        // op_valid stays high through the walk and must be ignored
        waitDrain(drainCycles);
        checkOutput("midreset_drain_len", drainCycles, 30);
        checkOutput("busy_op_ignored", depth, 0);

        // Array was cleared: a refill after reset returns fresh data only
        applyStimulus(3'd1, 16'd1, 16'd0);
        applyStimulus(3'd1, 16'd2, 16'd0);
        applyStimulus(3'd1, 16'd3, 16'd0);
        applyStimulus(3'd5, 16'd0, 16'd0);
        checkOutput("post_reset_b", b, 1);
        checkOutput("post_reset_a", a, 0);
        checkOutput("post_reset_depth", depth, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
